reg_bank: RTL and testbench

// - Register storage array that sits directly upstream of the negedge read-port latches.
//   It drives their din inputs with combinational read data from two independent read addresses.
// - One synchronous write port, committed at posedge clk.
// - Read data is stable by the following negedge, so a posedge write is seen by the read latch in the same cycle.
// - Supports a sequenced bulk clear: one register per cycle, with a busy flag.
//

---
 rtl/reg_bank.sv | 107 ++++++++++
 tb/tb_reg_bank.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// reg_bank: register array with two combinational read ports, one posedge
// write port and a sequenced one-register-per-cycle bulk clear.
// Read data is taken straight from the array so a posedge write is visible
// to the downstream negedge read latches within the same cycle.
module reg_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy,
  output logic              wr_ack
);

  // state | meaning
  // IDLE  | writes accepted, waiting for clr_req
  // CLEAR | zeroing regs[clr_ptr] each cycle, writes dropped
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              busy_q, busy_d;
  logic              wr_ack_q, wr_ack_d;
  logic              wr_commit;
  logic [DATA_W-1:0] regs_q [NREGS];

  // Next-state, sweep pointer and write-accept decode.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy_d    = busy_q;
    wr_ack_d  = 1'b0;
    wr_commit = 1'b0;
    case (state_q)
      IDLE: begin
        // A write in the same cycle as clr_req still commits; the sweep
        // starts on the same edge.
        if (wr_en) begin
          wr_commit = 1'b1;
          wr_ack_d  = 1'b1;
        end
        if (clr_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
          busy_d    = 1'b1;
        end
      end
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == ADDR_W'(NREGS - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      clr_ptr_q <= '0;
      busy_q    <= 1'b0;
      wr_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
      wr_ack_q  <= wr_ack_d;
    end
  end

  // Storage array: host write in IDLE, sweep clear in CLEAR (never both).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_commit) begin
      regs_q[wr_addr] <= wr_data;
    end else if (state_q == CLEAR) begin
      regs_q[clr_ptr_q] <= '0;
    end
  end

  assign rd_data_a = regs_q[rd_addr_a];
  assign rd_data_b = regs_q[rd_addr_b];
  assign busy      = busy_q;
  assign wr_ack    = wr_ack_q;

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: directed scenarios followed by random traffic, all
// compared against an array-based model of the register file.
module tb_reg_bank;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clr_req;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        busy;
  logic        wr_ack;

  reg_bank #(.DATA_W(32), .ADDR_W(4), .NREGS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_req   (clr_req),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .busy      (busy),
    .wr_ack    (wr_ack)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // Reference model: contents, sweep in progress flag, next index to clear.
  logic [31:0] m_mem [16];
  bit          m_busy;
  bit          m_ack;
  int          m_k;

  int n_checks = 0;
  int n_fail   = 0;

  // Values seen right after the last clock edge, before the address scan.
  logic [31:0] obs_a, obs_b;
  logic        obs_busy, obs_ack;

  int busy_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
    m_busy = 1'b0;
    m_ack  = 1'b0;
    m_k    = 0;
  endtask

  // One clock of the register-file rules applied to the current inputs.
  task automatic m_clock();
    bit ack_new;
    ack_new = 1'b0;
    if (!m_busy) begin
      if (wr_en) begin
        m_mem[wr_addr] = wr_data;
        ack_new = 1'b1;
      end
      if (clr_req) begin
        m_busy = 1'b1;
        m_k    = 0;
      end
    end else begin
      m_mem[m_k] = 32'h0;
      m_k++;
      if (m_k == 16) m_busy = 1'b0;
    end
    m_ack = ack_new;
  endtask

  // Flags plus every address on both read ports.
  task automatic check_all();
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("wr_ack", {31'b0, wr_ack}, {31'b0, m_ack});
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i);
      rd_addr_b = 4'(15 - i);
      #1;
      chk("scan_a", rd_data_a, m_mem[i]);
      chk("scan_b", rd_data_b, m_mem[15 - i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    m_clock();
    #1;
    obs_a    = rd_data_a;
    obs_b    = rd_data_b;
    obs_busy = busy;
    obs_ack  = wr_ack;
    chk("rd_a", rd_data_a, m_mem[rd_addr_a]);
    chk("rd_b", rd_data_b, m_mem[rd_addr_b]);
    check_all();
  endtask

  task automatic idle_inputs();
    wr_en   = 1'b0;
    wr_addr = 4'h0;
    wr_data = 32'h0;
    clr_req = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    rd_addr_a = 4'h0;
    rd_addr_b = 4'h0;
    m_reset();
    #3 rst = 1'b0;

    // 1: asynchronous reset mid-cycle wipes previously written data.
    do_write(4'h5, 32'h1234_5678);
    do_write(4'h9, 32'hCAFE_F00D);
    step();
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk("t1_busy", {31'b0, busy}, 32'h0);
    chk("t1_ack", {31'b0, wr_ack}, 32'h0);
    check_all();
    rst = 1'b0;

    // 2: write then same-cycle read, ack on the following cycle.
    rd_addr_a = 4'h5;
    do_write(4'h5, 32'hDEAD_BEEF);
    chk("t2_rd", obs_a, 32'hDEAD_BEEF);
    chk("t2_ack", {31'b0, obs_ack}, 32'h1);
    step();
    chk("t2_ack_drop", {31'b0, obs_ack}, 32'h0);

    // 3: back-to-back writes to the same register, both ports on it.
    rd_addr_a = 4'h3;
    rd_addr_b = 4'h3;
    wr_en = 1'b1; wr_addr = 4'h3; wr_data = 32'h1111_1111;
    step();
    chk("t3_ack1", {31'b0, obs_ack}, 32'h1);
    rd_addr_a = 4'h3;
    rd_addr_b = 4'h3;
    wr_data = 32'h2222_2222;
    step();
    chk("t3_ack2", {31'b0, obs_ack}, 32'h1);
    chk("t3_rd_a", obs_a, 32'h2222_2222);
    chk("t3_rd_b", obs_b, 32'h2222_2222);
    wr_en = 1'b0;
    step();
    chk("t3_ack_end", {31'b0, obs_ack}, 32'h0);

    // 4: fill with addr+1 then sweep; busy high for exactly 16 cycles.
    for (int i = 0; i < 16; i++) do_write(4'(i), 32'(i + 1));
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    busy_cnt = obs_busy ? 1 : 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (obs_busy) busy_cnt++;
    end
    chk("t4_busy_len", 32'(busy_cnt), 32'd16);

    // 5: write during the sweep is dropped.
    do_write(4'hF, 32'h5555_5555);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();
    step();
    do_write(4'hF, 32'h0000_ABCD);
    chk("t5_ack", {31'b0, obs_ack}, 32'h0);
    for (int k = 0; k < 14; k++) step();
    chk("t5_busy_end", {31'b0, obs_busy}, 32'h0);
    rd_addr_a = 4'hF;
    #1;
    chk("t5_rd15", rd_data_a, 32'h0);

    // 6: reset at sweep cycle 7 aborts; a later write works.
    for (int i = 0; i < 16; i++) do_write(4'(i), 32'hA000_0000 | 32'(i));
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int k = 0; k < 7; k++) step();
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", {31'b0, busy}, 32'h0);
    m_reset();
    check_all();
    rst = 1'b0;
    rd_addr_a = 4'h2;
    do_write(4'h2, 32'h0BAD_F00D);
    chk("t6_ack", {31'b0, obs_ack}, 32'h1);
    chk("t6_rd", obs_a, 32'h0BAD_F00D);

    // Held clr_req: sweep ignores it, then restarts on return to IDLE.
    clr_req = 1'b1;
    for (int k = 0; k < 20; k++) step();
    clr_req = 1'b0;
    for (int k = 0; k < 16; k++) step();

    // Random traffic.
    for (int n = 0; n < 250; n++) begin
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = 4'($urandom_range(0, 15));
      wr_data   = $urandom;
      clr_req   = ($urandom_range(0, 24) == 0);
      rd_addr_a = 4'($urandom_range(0, 15));
      rd_addr_b = 4'($urandom_range(0, 15));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
